cmd_uart_responder: RTL and testbench
=====================================

// Module: cmd_uart_responder
// PURPOSE
//  Knight-side end of the remote command link. Receives 16-bit commands as two UART bytes (high byte first)
//  and presents them to cmd_proc. Returns 8-bit responses as single UART bytes (e.g. 8'hA5 positive ack
//  after calibration). Sits between the RX/TX pins of KnightsTour and the command processor.
// PARAMETERS
//  BAUD_DIV  2604  clk cycles per bit (50 MHz / 19200 baud); must be >= 4
//  TMO_BITS  24    bit periods allowed between end of high byte and start bit of low byte
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   asynchronous reset, active high
//  RX           in   1   serial in from RemoteComm, idle high, asynchronous to clk
//  TX           out  1   serial out to RemoteComm, idle high
//  cmd          out  16  last complete command, {byte0, byte1}
//  cmd_rdy      out  1   level: cmd valid and not yet consumed
//  clr_cmd_rdy  in   1   consumer acknowledges cmd
//  resp         in   8   response byte, sampled when send_resp=1
//  send_resp    in   1   1-cycle request to transmit resp
//  tx_busy      out  1   frame in progress on TX
//  resp_sent    out  1   level: last response fully sent; cleared by next accepted send_resp
// BEHAVIOUR
//  Reset values: TX=1, cmd=16'h0000, cmd_rdy=0, tx_busy=0, resp_sent=0; RX synchronizer flops=1; FSMs idle.
//  Frame: 1 start(0), 8 data LSB first, 1 stop(1); BAUD_DIV clk per bit.
//  RX path:
//  - RX passes a 2-flop synchronizer (reset to 1); start = synced 1->0 transition while receiver idle.
//  - Sample at BAUD_DIV/2 after the edge (start-bit check), then every BAUD_DIV: 8 data bits, then stop.
//  - Start sample = 1 -> false start, return to idle, no byte.
//  - Stop sample = 0 -> framing error: byte dropped, assembler returns to WAIT_HI.
//  Assembler FSM, states WAIT_HI, WAIT_LO:
//  - WAIT_HI + good byte -> hold byte in hi_byte, go WAIT_LO, clear timeout counter.
//  - WAIT_LO + good byte -> cmd <= {hi_byte, byte}; cmd_rdy <= 1 on the cycle after the stop sample; go WAIT_HI.
//  - WAIT_LO: no start bit within TMO_BITS*BAUD_DIV clk of high-byte stop sample -> drop hi_byte, go WAIT_HI.
//  - cmd is updated only on completion; cmd holds its value between commands.
//  - cmd_rdy clears on clr_cmd_rdy. It also clears on the start bit of a new high byte (consumer missed it).
//  - clr_cmd_rdy in the same cycle as a completion: set wins, cmd_rdy stays 1.
//  - New command completing while cmd_rdy=1: cmd overwritten, cmd_rdy stays 1.
//  TX path, states IDLE, SHIFT:
//  - IDLE + send_resp: latch {1,resp,0} into 10-bit shifter; tx_busy=1 and resp_sent=0 next cycle.
//  - Start bit appears on TX the cycle after send_resp.
//  - Shift one bit per BAUD_DIV clk. After the stop bit's full period: tx_busy=0, resp_sent=1, back to IDLE.
//  - Latency send_resp -> resp_sent = 1 + 10*BAUD_DIV clk.
//  - send_resp while tx_busy: ignored; the frame in progress is unaffected, and resp is not re-sampled.
//  - RX and TX are fully independent: full duplex, no shared counters.
//  - rst asserted mid-frame: TX forced to 1 immediately. Partial RX byte and hi_byte discarded.
//    All outputs return to reset values.
//  Arithmetic: baud counters are $clog2(BAUD_DIV)+1 bits; bit counters 4 bits; timeout counter sized for
//  TMO_BITS*BAUD_DIV; no wrap reachable.
// TESTING (bench uses BAUD_DIV=16, TMO_BITS=24; a UART model drives RX and checks TX)
//  1 Reset: hold rst 3 clk mid-activity -> TX=1, cmd=0, cmd_rdy=0, tx_busy=0, resp_sent=0.
//  2 Command: send bytes 8'h2C then 8'h05 -> cmd=16'h2C05, cmd_rdy=1.
//    Pulse clr_cmd_rdy -> cmd_rdy=0 next clk, cmd still 16'h2C05.
//  3 Response: send_resp with resp=8'hA5 -> TX shows 0,1,0,1,0,0,1,0,1,1 at 16-clk bit periods;
//    resp_sent=1 exactly 161 clk after send_resp.
//    A second send_resp (resp=8'h5A) mid-frame -> still 8'hA5 received, no second frame.
//  4 Timeout/resync: send 8'h11, idle 30 bit times, send 8'h22, 8'h33 -> cmd=16'h2233 (8'h11 dropped).
//  5 Framing error: byte 8'h44 with stop bit 0, then 8'h12, 8'h34 -> cmd=16'h1234, one cmd_rdy assertion.
//    A 4-clk RX glitch low -> no byte.
//  6 Full duplex and simultaneity: transmit 8'hA5 while receiving 16'hBEEF -> both intact.
//    clr_cmd_rdy on the completion cycle -> cmd_rdy=1.

Source files
------------

// File: rtl/cmd_uart_responder.sv
// -----------------------------------------------------------------------------
// cmd_uart_responder
//   Knight-side end of the remote command link. Assembles 16-bit commands from
//   two received UART bytes (high byte first) for the command processor, and
//   transmits 8-bit response bytes back. The RX and TX paths are independent
//   (full duplex). Frame format: 1 start (0), 8 data LSB first, 1 stop (1).
//
// Parameters
//   BAUD_DIV     clk cycles per bit (>= 4)
//   TMO_BITS     bit periods allowed between the high byte's stop sample and
//                the low byte's start bit
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   RX           serial input, idle high, asynchronous to clk
//   TX           serial output, idle high
//   cmd          last complete command {high byte, low byte}
//   cmd_rdy      cmd valid and not yet consumed (level)
//   clr_cmd_rdy  consumer acknowledge for cmd
//   resp         response byte, sampled when send_resp is accepted
//   send_resp    one-cycle request to transmit resp
//   tx_busy      a TX frame is in progress
//   resp_sent    last response fully sent (level)
// -----------------------------------------------------------------------------
module cmd_uart_responder #(
  parameter int BAUD_DIV = 2604,
  parameter int TMO_BITS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        tx_busy,
  output logic        resp_sent
);

  localparam int BCW      = $clog2(BAUD_DIV) + 1;
  localparam int TMO_CLKS = TMO_BITS * BAUD_DIV;
  localparam int TCW      = $clog2(TMO_CLKS) + 1;

  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
  localparam logic [BCW-1:0] BAUD_HALF = BCW'(BAUD_DIV / 2 - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TMO_CLKS - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic ASM_WAIT_HI = 1'b0;
  localparam logic ASM_WAIT_LO = 1'b1;

  localparam logic TX_IDLE  = 1'b0;
  localparam logic TX_SHIFT = 1'b1;

  // ---------------------------------------------------------------------------
  // RX bit engine
  // ---------------------------------------------------------------------------
  logic           rx_s1, rx_s2, rx_prev;
  logic [1:0]     rx_state;
  logic [BCW-1:0] rx_cnt;
  logic [3:0]     rx_bits;
  logic [7:0]     rx_shift;
  logic           rx_fall, rx_tick, start_ok, stop_tick, byte_ok, byte_bad;

  assign rx_fall   = rx_prev & ~rx_s2;
  // The start bit is checked half a bit after the edge; every later sample
  // is a full bit period after the previous one, landing mid-bit.
  assign rx_tick   = (rx_cnt == ((rx_state == RX_START) ? BAUD_HALF : BAUD_LAST));
  assign start_ok  = (rx_state == RX_START) && rx_tick && !rx_s2;
  assign stop_tick = (rx_state == RX_STOP) && rx_tick;
  assign byte_ok   = stop_tick &&  rx_s2;
  assign byte_bad  = stop_tick && !rx_s2;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_fall) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_bits  <= '0;
            // A line already back high is a glitch, not a start bit.
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bits  <= rx_bits + 1'b1;
            if (rx_bits == 4'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin  // RX_STOP
          if (rx_tick) rx_state <= RX_IDLE;
          else         rx_cnt   <= rx_cnt + 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Command assembler
  // ---------------------------------------------------------------------------
  logic           asm_state;
  logic [7:0]     hi_byte;
  logic [TCW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_state <= ASM_WAIT_HI;
      hi_byte   <= '0;
      tmo_cnt   <= '0;
      cmd       <= '0;
    end else begin
      case (asm_state)
        ASM_WAIT_HI: begin
          if (byte_ok) begin
            hi_byte   <= rx_shift;
            tmo_cnt   <= '0;
            asm_state <= ASM_WAIT_LO;
          end
        end
        default: begin  // ASM_WAIT_LO
          if (byte_ok) begin
            cmd       <= {hi_byte, rx_shift};
            asm_state <= ASM_WAIT_HI;
          end else if (byte_bad) begin
            asm_state <= ASM_WAIT_HI;
          end else if ((rx_state == RX_IDLE) && !rx_fall) begin
            // Only idle line time counts; once a low byte has started it
            // is allowed to finish.
            if (tmo_cnt == TMO_LAST) asm_state <= ASM_WAIT_HI;
            else                     tmo_cnt   <= tmo_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Completion has priority over any clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          cmd_rdy <= 1'b0;
    else if ((asm_state == ASM_WAIT_LO) && byte_ok)   cmd_rdy <= 1'b1;
    else if (clr_cmd_rdy ||
             ((asm_state == ASM_WAIT_HI) && start_ok)) cmd_rdy <= 1'b0;
  end

  // ---------------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------------
  logic           tx_state;
  logic [9:0]     tx_shift;
  logic [BCW-1:0] tx_cnt;
  logic [3:0]     tx_bits;

  // TX comes straight from a flop that resets to 1, so reset idles the line
  // immediately and glitch-free.
  assign TX      = tx_shift[0];
  assign tx_busy = (tx_state == TX_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_shift  <= '1;
      tx_cnt    <= '0;
      tx_bits   <= '0;
      resp_sent <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_shift  <= {1'b1, resp, 1'b0};
            tx_cnt    <= '0;
            tx_bits   <= '0;
            resp_sent <= 1'b0;
            tx_state  <= TX_SHIFT;
          end
        end
        default: begin  // TX_SHIFT: send_resp is ignored here
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt <= '0;
            if (tx_bits == 4'd9) begin
              tx_shift  <= '1;
              resp_sent <= 1'b1;
              tx_state  <= TX_IDLE;
            end else begin
              tx_shift <= {1'b1, tx_shift[9:1]};
              tx_bits  <= tx_bits + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_uart_responder.sv
// -----------------------------------------------------------------------------
// tb_cmd_uart_responder
//   Directed bench for cmd_uart_responder with BAUD_DIV=16, TMO_BITS=24.
//   A UART model drives RX; TX is sampled and compared bit by bit.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cmd_uart_responder;

  localparam int BD  = 16;
  localparam int TMO = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        tx_busy;
  logic        resp_sent;

  int n_assert = 0;
  int n_fail   = 0;
  int rdy_rises = 0;
  logic rdy_q = 1'b0;

  cmd_uart_responder #(.BAUD_DIV(BD), .TMO_BITS(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .tx_busy     (tx_busy),
    .resp_sent   (resp_sent)
  );

  always #5 clk = ~clk;

  // Counts 0->1 transitions of cmd_rdy.
  always @(posedge clk) begin
    rdy_q <= cmd_rdy;
    if (cmd_rdy && !rdy_q) rdy_rises++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends one UART frame on RX; entered and left on a falling edge.
  // With clr_at_done, clr_cmd_rdy is held through the stop bit until cmd_rdy
  // is seen high, which exercises a clear coinciding with completion.
  task automatic uart_send(input logic [7:0] b, input logic stop_val, input logic clr_at_done);
    logic [9:0] fr;
    logic       seen;
    fr   = {stop_val, b, 1'b0};
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      if (i == 9 && clr_at_done) clr_cmd_rdy = 1'b1;
      for (int c = 0; c < BD; c++) begin
        @(negedge clk);
        if (i == 9 && clr_at_done && !seen && cmd_rdy) begin
          seen        = 1'b1;
          clr_cmd_rdy = 1'b0;
        end
      end
    end
    if (clr_at_done) begin
      clr_cmd_rdy = 1'b0;
      check("set_wins_over_clr", seen, 1'b1);
    end
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    logic [9:0] fr;
    logic [9:0] cap;
    int         r0;

    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; resp = 8'h00; send_resp = 1'b0;
    wait_clk(3);
    check("por_tx", TX, 1'b1);
    check("por_cmd", cmd, 16'h0000);
    check("por_cmd_rdy", cmd_rdy, 1'b0);
    check("por_tx_busy", tx_busy, 1'b0);
    check("por_resp_sent", resp_sent, 1'b0);
    rst = 1'b0;
    wait_clk(2 * BD);

    // ---- Command 0x2C05 and acknowledge ----
    uart_send(8'h2C, 1'b1, 1'b0);
    check("hi_only_no_rdy", cmd_rdy, 1'b0);
    uart_send(8'h05, 1'b1, 1'b0);
    check("cmd_2c05", cmd, 16'h2C05);
    check("cmd_rdy_set", cmd_rdy, 1'b1);
    check("rdy_rises_1", rdy_rises, 1);
    pulse_clr();
    check("cmd_rdy_cleared", cmd_rdy, 1'b0);
    check("cmd_held", cmd, 16'h2C05);

    // ---- Response 0xA5, exact bit timing, mid-frame send ignored ----
    fr = {1'b1, 8'hA5, 1'b0};
    resp = 8'hA5;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    check("tx_busy_next", tx_busy, 1'b1);
    check("resp_sent_cleared", resp_sent, 1'b0);
    for (int k = 1; k <= 160; k++) begin
      if ((k % BD == 1) || (k % BD == 0)) check("tx_bit", TX, fr[(k - 1) / BD]);
      if (k == 50) begin resp = 8'h5A; send_resp = 1'b1; end
      if (k == 51) send_resp = 1'b0;
      if (k == 160) begin
        check("resp_sent_160", resp_sent, 1'b0);
        check("tx_busy_160", tx_busy, 1'b1);
      end
      @(negedge clk);
    end
    check("resp_sent_161", resp_sent, 1'b1);
    check("tx_busy_161", tx_busy, 1'b0);
    check("tx_idle_161", TX, 1'b1);
    wait_clk(3 * BD);
    check("no_second_frame_busy", tx_busy, 1'b0);
    check("no_second_frame_tx", TX, 1'b1);
    check("resp_sent_holds", resp_sent, 1'b1);

    // ---- Timeout drops a lone high byte ----
    uart_send(8'h11, 1'b1, 1'b0);
    RX = 1'b1;
    wait_clk(30 * BD);
    uart_send(8'h22, 1'b1, 1'b0);
    uart_send(8'h33, 1'b1, 1'b0);
    check("cmd_2233", cmd, 16'h2233);
    check("cmd_rdy_2233", cmd_rdy, 1'b1);
    pulse_clr();

    // ---- Framing error, then glitch ----
    r0 = rdy_rises;
    uart_send(8'h44, 1'b0, 1'b0);
    RX = 1'b1;
    wait_clk(2 * BD);
    uart_send(8'h12, 1'b1, 1'b0);
    uart_send(8'h34, 1'b1, 1'b0);
    check("cmd_1234", cmd, 16'h1234);
    check("one_rdy_rise", rdy_rises - r0, 1);
    pulse_clr();
    RX = 1'b0;
    wait_clk(4);
    RX = 1'b1;
    wait_clk(2 * BD);
    check("glitch_no_rdy", cmd_rdy, 1'b0);
    check("glitch_cmd_held", cmd, 16'h1234);
    uart_send(8'h56, 1'b1, 1'b0);
    uart_send(8'h78, 1'b1, 1'b0);
    check("cmd_5678_after_glitch", cmd, 16'h5678);
    pulse_clr();

    // ---- Full duplex: send 0xA5 while receiving 0xBEEF ----
    cap = '0;
    fork
      begin
        uart_send(8'hBE, 1'b1, 1'b0);
        uart_send(8'hEF, 1'b1, 1'b1);
      end
      begin
        resp = 8'hA5;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        wait_clk(BD / 2 - 1);
        cap[0] = TX;
        for (int i = 1; i < 10; i++) begin
          wait_clk(BD);
          cap[i] = TX;
        end
      end
    join
    check("duplex_tx_frame", cap, {1'b1, 8'hA5, 1'b0});
    check("duplex_cmd_beef", cmd, 16'hBEEF);
    check("duplex_resp_sent", resp_sent, 1'b1);
    @(negedge clk);
    check("cmd_rdy_after_set_wins", cmd_rdy, 1'b1);

    // ---- Reset mid-activity ----
    resp = 8'h3C;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    RX = 1'b0;
    wait_clk(40);
    check("pre_reset_tx_low", TX, 1'b0);
    rst = 1'b1;
    RX = 1'b1;
    #1;
    check("rst_tx_immediate", TX, 1'b1);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_cmd_rdy", cmd_rdy, 1'b0);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_resp_sent", resp_sent, 1'b0);
    wait_clk(3);
    rst = 1'b0;
    check("post_rst_tx", TX, 1'b1);
    check("post_rst_cmd", cmd, 16'h0000);
    wait_clk(2 * BD);
    uart_send(8'h9A, 1'b1, 1'b0);
    uart_send(8'hBC, 1'b1, 1'b0);
    check("cmd_9abc_after_rst", cmd, 16'h9ABC);
    check("cmd_rdy_9abc", cmd_rdy, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
